btn_step_ctrl: RTL and testbench
================================

BTN_STEP_CTRL -- requirements
Module: btn_step_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to accept a button level change.
REQ-002 Parameter REPEAT_DELAY, default 50000000: cycles from first step pulse to first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 20000000: cycles between later auto-repeat pulses.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 btn_up  input  1  raw, asynchronous, bouncing "increment" button, active-high.
REQ-007 btn_down  input  1  raw, asynchronous, bouncing "decrement" button, active-high.
REQ-008 en  output  1  one-cycle step pulse; drives the enable input of the downstream Mod_N_Counter instances.
REQ-009 Up_Down_en  output  1  count direction for the downstream counters: 1 = up, 0 = down.

Function
REQ-010 Each button SHALL pass through a two-flop synchroniser before any other logic.
REQ-011 Each button SHALL have its own debounce counter sized by $clog2(DEBOUNCE_CYCLES+1).
- The debounced level updates after DEBOUNCE_CYCLES consecutive cycles in which the synchronised level differs from it.
- Any cycle with agreement clears that counter.
REQ-012 The FSM SHALL have the states IDLE, DELAY, REPEAT and WAIT_RELEASE.
REQ-013 In IDLE, when exactly one debounced button rises:
- en is high for exactly one cycle.
- Up_Down_en updates in the same cycle (1 for up, 0 for down).
- The FSM moves to DELAY.
REQ-014 A raw press that is stable from cycle 0 SHALL produce en high at cycle DEBOUNCE_CYCLES+3.
REQ-015 If both debounced buttons are high in IDLE, whether they rose in the same cycle or one is already held, the FSM SHALL go to WAIT_RELEASE with no pulse.
REQ-016 In DELAY or REPEAT:
- Debounced release of the active button returns the FSM to IDLE with no pulse.
- A debounced press of the other button sends the FSM to WAIT_RELEASE with no pulse.
REQ-017 WAIT_RELEASE SHALL return to IDLE only once both debounced buttons are low; it never pulses.
REQ-018 Up_Down_en SHALL hold its last value between pulses.
REQ-019 en SHALL never be high in two consecutive cycles.
REQ-020 All timing counters SHALL saturate or reload; none SHALL wrap to produce a spurious pulse.

Reset
REQ-021 While rst is low, asynchronously:
- en = 0 and Up_Down_en = 1.
- Synchronisers, debounced levels and all counters = 0.
- FSM = IDLE.
REQ-022 Reset asserted mid-DELAY or mid-REPEAT SHALL abort immediately.
REQ-023 After reset release, a button still held SHALL be treated as a new press and pulse per REQ-014, counted from reset release.

Configuration
REQ-024 With macro AUTO_REPEAT_EN defined, holding a button:
- After REPEAT_DELAY cycles in DELAY, en pulses and the FSM moves to REPEAT.
- In REPEAT, en pulses every REPEAT_PERIOD cycles.
REQ-025 Without AUTO_REPEAT_EN:
- DELAY and REPEAT timers are not synthesised.
- After the first pulse the FSM goes directly to WAIT_RELEASE, giving exactly one pulse per press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-026 Macro off; btn_up high from cycle 0 for 40 cycles -> single en pulse at cycle 7, Up_Down_en=1, no further pulses.
REQ-027 btn_up toggles every 2 cycles for 12 cycles, then stays low -> en never asserted, Up_Down_en stays 1.
REQ-028 Macro on; btn_down held 0..29 -> pulses at cycles 7, 17, 20, 23, 26, 29, then every 3 cycles until the debounced release, none after cycle 37; Up_Down_en=0 from cycle 7.
REQ-029 btn_up and btn_down rise in the same cycle and are held 20 cycles, then released; btn_up pressed 20 cycles later -> no pulse during the dual press, then exactly one up pulse 7 cycles after the new press.
REQ-030 Macro on; rst driven low at cycle 18 while btn_up is held, released at cycle 22 -> en=0 and Up_Down_en=1 during reset, next pulse at cycle 29.

Source files
------------

// File: rtl/btn_step_ctrl.sv
// btn_step_ctrl: synchronises and debounces up/down buttons into one-cycle step pulses plus count direction.
// Latency: a press stable from cycle 0 pulses at cycle DEBOUNCE_CYCLES+3; optional hold-to-repeat via AUTO_REPEAT_EN.
// Backpressure: none; en is a fire-and-forget pulse and Up_Down_en holds between pulses.
module btn_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    output logic en,
    output logic Up_Down_en
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, WAIT_RELEASE} state_t;

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("btn_step_ctrl: timing parameters must be at least 1");
    end

    // Bit 0 is the up button, bit 1 the down button throughout.
    logic [1:0]            w_raw;
    logic [1:0]            r_sync1;
    logic [1:0]            r_sync2;
    logic [1:0]            r_deb;
    logic [1:0]            r_rise;
    logic [1:0][DB_W-1:0]  r_db_cnt;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_en;
    logic   w_en_nxt;
    logic   r_dir;
    logic   w_dir_nxt;

    assign w_raw      = {btn_down, btn_up};
    assign en         = r_en;
    assign Up_Down_en = r_dir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_deb    <= '0;
            r_rise   <= '0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                r_rise[i] <= 1'b0;
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_cnt[i] <= '0;
                    r_deb[i]    <= r_sync2[i];
                    r_rise[i]   <= r_sync2[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int TM_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TM_W   = $clog2(TM_MAX + 1);
    localparam logic [TM_W-1:0] DLY_LAST = TM_W'(REPEAT_DELAY - 1);
    localparam logic [TM_W-1:0] PER_LAST = TM_W'(REPEAT_PERIOD - 1);

    logic [TM_W-1:0] r_tmr;
    logic            w_tmr_done;
    logic            w_act_held;
    logic            w_oth_held;

    assign w_tmr_done = (r_state == DELAY) ? (r_tmr == DLY_LAST) : (r_tmr == PER_LAST);
    assign w_act_held = r_dir ? r_deb[0] : r_deb[1];
    assign w_oth_held = r_dir ? r_deb[1] : r_deb[0];

    // Reloads on every pulse and holds once expired, so it can never wrap into a stray pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmr <= '0;
        end else if (w_en_nxt || (r_state != DELAY && r_state != REPEAT)) begin
            r_tmr <= '0;
        end else if (!w_tmr_done) begin
            r_tmr <= r_tmr + 1'b1;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = 1'b0;
        w_dir_nxt   = r_dir;
        case (r_state)
            IDLE: begin
                if (&r_deb) begin
                    w_state_nxt = WAIT_RELEASE;
                end else if (r_rise[0] || r_rise[1]) begin
                    w_en_nxt  = 1'b1;
                    w_dir_nxt = r_rise[0];
`ifdef AUTO_REPEAT_EN
                    w_state_nxt = DELAY;
`else
                    w_state_nxt = WAIT_RELEASE;
`endif
                end
            end
`ifdef AUTO_REPEAT_EN
            DELAY, REPEAT: begin
                // The other button wins over a release or an expiring timer on the same cycle.
                if (w_oth_held) begin
                    w_state_nxt = WAIT_RELEASE;
                end else if (!w_act_held) begin
                    w_state_nxt = IDLE;
                end else if (w_tmr_done && !r_en) begin
                    w_en_nxt    = 1'b1;
                    w_state_nxt = REPEAT;
                end
            end
`endif
            WAIT_RELEASE: begin
                if (r_deb == 2'b00) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_en    <= 1'b0;
            r_dir   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_en    <= w_en_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Directed bench for btn_step_ctrl with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Expectations follow AUTO_REPEAT_EN so the same bench serves both builds.
module tb_btn_step_ctrl;
    logic clk;
    logic rst;
    logic btn_up;
    logic btn_down;
    logic en;
    logic Up_Down_en;

`ifdef AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct {
        logic rst_n;
        logic up;
        logic dn;
        logic exp_en;
        logic exp_dir;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    btn_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .en        (en),
        .Up_Down_en(Up_Down_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic u, input logic d,
                                input logic e, input logic dir);
        vq.push_back('{rst_n: r, up: u, dn: d, exp_en: e, exp_dir: dir});
    endfunction

    // Two reset rows then two quiet rows; the scenario's cycle 0 follows directly.
    function automatic void prelude();
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    task automatic check(input string name, input logic act, input logic exp, input int row);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
        end
    endtask

    initial begin
        logic e;
        int   k;

        rst      = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;

        // A: up held 0..39
        prelude();
        for (int c = 0; c < 60; c++) begin
            e = (c == 7) || (AUTO && c >= 17 && c <= 44 && (c - 17) % 3 == 0);
            add(1'b1, c < 40, 1'b0, e, 1'b1);
        end
        // B: down held 0..29
        prelude();
        for (int c = 0; c < 45; c++) begin
            e = (c == 7) || (AUTO && c >= 17 && c <= 35 && (c - 17) % 3 == 0);
            add(1'b1, 1'b0, c < 30, e, (c >= 7) ? 1'b0 : 1'b1);
        end
        // C: up bouncing every 2 cycles never settles
        prelude();
        for (int c = 0; c < 25; c++) begin
            add(1'b1, (c < 12) && ((c / 2) % 2 == 0), 1'b0, 1'b0, 1'b1);
        end
        // D: simultaneous press, release, then a clean up press at 40
        prelude();
        for (int c = 0; c < 60; c++) begin
            add(1'b1, (c < 20) || (c >= 40 && c < 50), c < 20, c == 47, 1'b1);
        end
        // E: reset pulled low 18..21 while up is held
        prelude();
        for (int c = 0; c < 35; c++) begin
            e = (c == 7) || (c == 29) || (AUTO && c == 17);
            add(!(c >= 18 && c < 22), c < 35, 1'b0, e, 1'b1);
        end
        // F: down pressed while up is in its delay window
        prelude();
        for (int c = 0; c < 45; c++) begin
            add(1'b1, c < 30, (c >= 10 && c < 20), c == 7, 1'b1);
        end

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            rst      = vq[i].rst_n;
            btn_up   = vq[i].up;
            btn_down = vq[i].dn;
            @(negedge clk);
            check("en", en, vq[i].exp_en, i);
            check("Up_Down_en", Up_Down_en, vq[i].exp_dir, i);
        end

        // Async reset must restore direction mid-cycle, then a held button re-presses from release.
        @(posedge clk);
        #1;
        btn_up   = 1'b0;
        btn_down = 1'b1;
        for (int c = 1; c < 12; c++) @(posedge clk);
        @(negedge clk);
        check("dir_after_down", Up_Down_en, 1'b0, 0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_dir", Up_Down_en, 1'b1, 0);
        check("async_rst_en", en, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (en === 1'b1) break;
            k++;
        end
        check("held_after_rst_seen", (k < 20), 1'b1, k);
        checks++;
        if (k != 7) begin
            errors++;
            $display("FAIL held_after_rst_latency: got %0d cycles expected 7", k);
        end
        check("held_after_rst_dir", Up_Down_en, 1'b0, k);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
